axi_interp_hold: RTL

AXI_INTERP_HOLD -- requirements
Module: axi_interp_hold

---
 rtl/axi_interp_hold.sv | 132 +++++++++++++
 1 files changed

// File: rtl/axi_interp_hold.sv
// Interpolating AXI-Stream hold stage: each accepted sample is emitted N times (zero-order hold).
// Define AXI_INTERP_HOLD_ZERO_STUFF_EN to enable zero-stuff mode (cfg_mode = 1).
module axi_interp_hold #(
  parameter  int WIDTH = 32,
  parameter  int MAX_N = 255,
  localparam int NW    = $clog2(MAX_N + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NW-1:0]    cfg_n,
  input  logic             cfg_mode,
  input  logic [15:0]      cfg_spp,
  input  logic [WIDTH-1:0] s_axis_tdata,
  input  logic             s_axis_tlast,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  output logic [WIDTH-1:0] m_axis_tdata,
  output logic             m_axis_tlast,
  output logic             m_axis_tvalid,
  output logic             m_axis_teob,
  input  logic             m_axis_tready,
  output logic             err_cfg
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic             hold_vld_q, hold_vld_d;
  logic [WIDTH-1:0] hold_data_q, hold_data_d;
  logic             hold_eob_q, hold_eob_d;
  logic [NW-1:0]    copy_q, copy_d;
  logic [NW-1:0]    n_q, n_d;
  logic             mode_q, mode_d;
  logic [15:0]      spp_q, spp_d;
  logic [15:0]      pkt_q, pkt_d;
  logic             err_q, err_d;

  logic last_copy, m_xfer, s_acc, burst_end, start, pkt_wrap;

  assign last_copy = (copy_q == n_q - NW'(1));
  assign m_xfer    = hold_vld_q & m_axis_tready;
  assign burst_end = m_xfer & last_copy & hold_eob_q;
  assign pkt_wrap  = (spp_q != 16'd0) && (pkt_q == spp_q - 16'd1);

  // Gating with rst_n keeps tready low during reset even though the hold register reads empty.
  assign s_axis_tready = rst_n & (~hold_vld_q | (m_xfer & last_copy));
  assign s_acc         = s_axis_tvalid & s_axis_tready;
  // A sample accepted while the EOB sample drains its last copy opens the next burst.
  assign start         = s_acc & ((state_q == IDLE) | burst_end);

  assign m_axis_tvalid = hold_vld_q;
  assign m_axis_tdata  = (mode_q && copy_q != '0) ? '0 : hold_data_q;
  assign m_axis_teob   = hold_vld_q & last_copy & hold_eob_q;
  assign m_axis_tlast  = hold_vld_q & ((last_copy & hold_eob_q) | pkt_wrap);
  assign err_cfg       = err_q;

`ifndef AXI_INTERP_HOLD_ZERO_STUFF_EN
  logic unused_cfg_mode;
  assign unused_cfg_mode = cfg_mode;
`endif

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through this block infers a latch.
    state_d     = state_q;
    hold_vld_d  = hold_vld_q;
    hold_data_d = hold_data_q;
    hold_eob_d  = hold_eob_q;
    copy_d      = copy_q;
    n_d         = n_q;
    mode_d      = mode_q;
    spp_d       = spp_q;
    pkt_d       = pkt_q;
    err_d       = err_q;

    if (m_xfer) begin
      copy_d = copy_q + NW'(1);
      if (last_copy) begin
        hold_vld_d = 1'b0;
        copy_d     = '0;
      end
      if ((last_copy && hold_eob_q) || pkt_wrap) pkt_d = 16'd0;
      else if (spp_q != 16'd0)                   pkt_d = pkt_q + 16'd1;
      if (burst_end) state_d = IDLE;
    end

    if (s_acc) begin
      hold_vld_d  = 1'b1;
      hold_data_d = s_axis_tdata;
      hold_eob_d  = s_axis_tlast;
      copy_d      = '0;
      state_d     = RUN;
      if (start) begin
        n_d   = (cfg_n == '0) ? NW'(1) : cfg_n;
        err_d = err_q | (cfg_n == '0);
        spp_d = cfg_spp;
`ifdef AXI_INTERP_HOLD_ZERO_STUFF_EN
        mode_d = cfg_mode;
`else
        mode_d = 1'b0;
`endif
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      hold_vld_q  <= 1'b0;
      hold_data_q <= '0;
      hold_eob_q  <= 1'b0;
      copy_q      <= '0;
      n_q         <= NW'(1);
      mode_q      <= 1'b0;
      spp_q       <= 16'd0;
      pkt_q       <= 16'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_vld_q  <= hold_vld_d;
      hold_data_q <= hold_data_d;
      hold_eob_q  <= hold_eob_d;
      copy_q      <= copy_d;
      n_q         <= n_d;
      mode_q      <= mode_d;
      spp_q       <= spp_d;
      pkt_q       <= pkt_d;
      err_q       <= err_d;
    end
  end

endmodule
